sys_arr_row_feeder: RTL

Upstream sequencer for `sysArrRow`. It accepts one weight/bias beat over a valid/ready handshake and writes it into every PE of the row. It buffers an 8-bit activation stream in a small FIFO and plays it into the row's `datain`/`active` inputs. It then flushes the row pipeline with zero data and reports completion. All outputs facing the row connect port-for-port to the row's inputs.

---
 rtl/sys_arr_pkg.sv | 20 ++
 rtl/sys_arr_fifo.sv | 59 +++++
 rtl/sys_arr_row_feeder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sys_arr_pkg.sv
// Shared types and constants for the systolic-array row feeder and its activation FIFO.
package sys_arr_pkg;

    localparam int DATA_W        = 8;
    localparam int SUM_W         = 16;
    localparam int ROW_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_STREAM,
        ST_DRAIN
    } feeder_state_e;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } act_beat_t;

endpackage

// File: rtl/sys_arr_fifo.sv
// Synchronous FIFO with register-array storage; the head entry is read straight from
// the array, so a beat is only visible after the edge that wrote it.
module sys_arr_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers are exactly AW bits wide, so incrementing past DEPTH-1 wraps to 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sys_arr_row_feeder.sv
// Sequencer for one systolic-array row: broadcasts a weight/bias beat, streams buffered
// activations into the row, then flushes the row pipeline with zeros and pulses done.
module sys_arr_row_feeder
    import sys_arr_pkg::*;
#(
    parameter int ROW_WIDTH = ROW_WIDTH_DEF,
    parameter int DEPTH     = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [DATA_W*ROW_WIDTH-1:0] w_data,
    input  logic [SUM_W*ROW_WIDTH-1:0]  b_data,
    input  logic                       d_valid,
    output logic                       d_ready,
    input  logic [DATA_W-1:0]          d_data,
    input  logic                       d_last,
    output logic [DATA_W*ROW_WIDTH-1:0] win,
    output logic [ROW_WIDTH-1:0]       wwrite,
    output logic [SUM_W*ROW_WIDTH-1:0]  sumin,
    output logic [DATA_W-1:0]          datain,
    output logic                       active,
    output logic                       busy,
    output logic                       done
);

    localparam int CW = $clog2(ROW_WIDTH + 1);

    feeder_state_e                 state_q;
    logic [DATA_W*ROW_WIDTH-1:0]   win_q;
    logic [ROW_WIDTH-1:0]          wwrite_q;
    logic [SUM_W*ROW_WIDTH-1:0]    sumin_q;
    logic [DATA_W-1:0]             datain_q;
    logic                          active_q;
    logic                          done_q;
    logic [CW-1:0]                 drain_q;

    act_beat_t fifo_wbeat;
    act_beat_t fifo_head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_pop;

    assign fifo_wbeat = '{last: d_last, data: d_data};
    assign fifo_pop   = (state_q == ST_STREAM) && !fifo_empty;

    sys_arr_fifo #(
        .WIDTH ($bits(act_beat_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .push_i  (d_valid),
        .wdata_i (fifo_wbeat),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            win_q    <= '0;
            wwrite_q <= '0;
            sumin_q  <= '0;
            datain_q <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            drain_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    datain_q <= '0;
                    active_q <= 1'b0;
                    wwrite_q <= '0;
                    if (w_valid) begin
                        win_q    <= w_data;
                        sumin_q  <= b_data;
                        wwrite_q <= '1;
                        state_q  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    wwrite_q <= '0;
                    state_q  <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (!fifo_empty) begin
                        datain_q <= fifo_head.data;
                        active_q <= 1'b1;
                        if (fifo_head.last) begin
                            drain_q <= CW'(ROW_WIDTH);
                            state_q <= ST_DRAIN;
                        end
                    end else begin
                        datain_q <= '0;
                        active_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Zero beats keep active high so every PE sees the tail of the vector.
                    datain_q <= '0;
                    active_q <= 1'b1;
                    drain_q  <= drain_q - 1'b1;
                    if (drain_q == CW'(1)) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign w_ready = (state_q == ST_IDLE);
    assign busy    = (state_q != ST_IDLE);
    assign d_ready = !fifo_full;
    assign win     = win_q;
    assign wwrite  = wwrite_q;
    assign sumin   = sumin_q;
    assign datain  = datain_q;
    assign active  = active_q;
    assign done    = done_q;

endmodule
